// File: rtl/flash_audio_sample_fsm.sv
// Walks a 16-bit audio image packed two samples per 32-bit flash word, one sample per tick.
// Latency: first sample of a word 3 + waitrequest cycles after its tick; second sample 1 cycle after its tick.
// Backpressure: honours Avalon waitrequest; ticks arriving while a word is fetched or emitted are dropped and flagged.
module flash_audio_sample_fsm #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              play,
  input  logic              direction,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] flash_address,
  output logic              flash_read,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_data,
  output logic              audio_valid,
  output logic              tick_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_OUT0,
    S_HOLD,
    S_OUT1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              read_nxt;
  logic [15:0]       data_nxt;
  logic              valid_nxt;
  logic              drop_nxt;
  logic [31:0]       word, word_nxt;
  logic              dir_word, dir_word_nxt;
  logic              restart_pending, pending_nxt;
  logic              restart_q;

  logic              rst_req;
  logic              tick_ok;
  logic [ADDR_W-1:0] restart_addr;
  logic [ADDR_W-1:0] adv_addr;

  assign rst_req      = restart & ~restart_q;
  assign tick_ok      = sample_tick & play;
  assign restart_addr = direction ? '0 : MAX_ADDR;

  // Next word address in the current playback direction, wrapping at both ends of the image.
  always_comb begin
    adv_addr = flash_address;
    if (direction) begin
      adv_addr = (flash_address == MAX_ADDR) ? '0 : flash_address + ADDR_W'(1);
    end else begin
      adv_addr = (flash_address == '0) ? MAX_ADDR : flash_address - ADDR_W'(1);
    end
  end

  // Next-state and output decode; audio outputs are loaded on the edge that enters OUT0/OUT1.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = flash_address;
    read_nxt     = flash_read;
    data_nxt     = audio_data;
    valid_nxt    = 1'b0;
    drop_nxt     = 1'b0;
    word_nxt     = word;
    dir_word_nxt = dir_word;
    pending_nxt  = restart_pending;

    case (state)
      S_IDLE: begin
        if (rst_req) begin
          addr_nxt = restart_addr;
        end else if (tick_ok) begin
          read_nxt  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        // A restart here is deferred so the Avalon read is never abandoned.
        if (rst_req) pending_nxt = 1'b1;
        else if (tick_ok) drop_nxt = 1'b1;
        if (!flash_waitrequest) begin
          read_nxt  = 1'b0;
          state_nxt = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (rst_req) pending_nxt = 1'b1;
        else if (tick_ok) drop_nxt = 1'b1;
        if (flash_readdatavalid) begin
          if (restart_pending || rst_req) begin
            addr_nxt    = restart_addr;
            pending_nxt = 1'b0;
            state_nxt   = S_IDLE;
          end else begin
            word_nxt     = flash_readdata;
            dir_word_nxt = direction;
            data_nxt     = direction ? flash_readdata[15:0] : flash_readdata[31:16];
            valid_nxt    = 1'b1;
            state_nxt    = S_OUT0;
          end
        end
      end
      S_OUT0: begin
        if (rst_req) begin
          addr_nxt  = restart_addr;
          state_nxt = S_IDLE;
        end else begin
          drop_nxt  = tick_ok;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rst_req) begin
          addr_nxt  = restart_addr;
          state_nxt = S_IDLE;
        end else if (tick_ok) begin
          data_nxt  = dir_word ? word[31:16] : word[15:0];
          valid_nxt = 1'b1;
          state_nxt = S_OUT1;
        end
      end
      S_OUT1: begin
        // Restart overrides the normal advance to the next word.
        if (rst_req) begin
          addr_nxt = restart_addr;
        end else begin
          drop_nxt = tick_ok;
          addr_nxt = adv_addr;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      flash_address   <= '0;
      flash_read      <= 1'b0;
      audio_data      <= '0;
      audio_valid     <= 1'b0;
      tick_dropped    <= 1'b0;
      word            <= '0;
      dir_word        <= 1'b0;
      restart_pending <= 1'b0;
      restart_q       <= 1'b0;
    end else begin
      state           <= state_nxt;
      flash_address   <= addr_nxt;
      flash_read      <= read_nxt;
      audio_data      <= data_nxt;
      audio_valid     <= valid_nxt;
      tick_dropped    <= drop_nxt;
      word            <= word_nxt;
      dir_word        <= dir_word_nxt;
      restart_pending <= pending_nxt;
      restart_q       <= restart;
    end
  end

endmodule

// File: doc/flash_audio_sample_fsm.md
Name: flash_audio_sample_fsm

Overview:
- Sits directly downstream of the keyboard command decoder.
- Consumes its restart, play/pause and direction controls and walks the audio image stored in flash over an Avalon-MM read master.
- Splits each 32-bit flash word into two 16-bit samples and emits one sample per sample_tick strobe to the audio output path.
- Handles forward and backward playback, pause, restart and address wrap-around.

Parameters:
- ADDR_W, 23, flash word-address width.
- MAX_ADDR, 23'h7FFFF, last word address of the audio image; the first is 0.

Ports:
- clk  input  1  system clock (50 MHz); every register is on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- restart  input  1  level from the keyboard decoder; a rising edge requests a restart.
- play  input  1  1 = playing, 0 = paused (the decoder's pause output).
- direction  input  1  1 = forward, 0 = backward.
- sample_tick  input  1  one-clk strobe at the sample rate, already synchronised to clk.
- flash_address  output  ADDR_W  Avalon word address.
- flash_read  output  1  Avalon read request.
- flash_waitrequest  input  1  Avalon waitrequest.
- flash_readdata  input  32  Avalon read data.
- flash_readdatavalid  input  1  Avalon read-data valid.
- audio_data  output  16  current sample; held between updates.
- audio_valid  output  1  one-clk pulse when audio_data updates.
- tick_dropped  output  1  one-clk pulse when sample_tick arrives and the block cannot accept it.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, flash_address=0, flash_read=0, audio_data=0, audio_valid=0, tick_dropped=0, word register=0, restart_pending=0, restart edge register=0.
- Restart edge detect: rst_req = restart & ~restart_q, with restart_q registered every cycle.
- States:
  - IDLE: on sample_tick&play go to FETCH with flash_read=1 on the next cycle.
  - FETCH: hold flash_read=1 and flash_address stable until a cycle with flash_waitrequest=0. Drop flash_read the following cycle and go to WAIT_DATA.
  - WAIT_DATA: on flash_readdatavalid latch flash_readdata into the word register and latch dir_word=direction, then go to OUT0. No timeout.
  - OUT0 (1 cycle): audio_data = dir_word ? word[15:0] : word[31:16]; audio_valid=1; go to HOLD.
  - HOLD: on sample_tick&play go to OUT1.
  - OUT1 (1 cycle): audio_data = dir_word ? word[31:16] : word[15:0]; audio_valid=1; advance the address; go to IDLE.
- Address advance, using the current direction:
  - Forward: flash_address+1, with MAX_ADDR wrapping to 0.
  - Backward: flash_address-1, with 0 wrapping to MAX_ADDR.
- Latency from an accepted tick:
  - The first sample's audio_valid comes 3 + waitrequest cycles + readdatavalid latency after the tick.
  - The second sample's audio_valid comes exactly 1 cycle after its tick.
- Pause:
  - play=0 ignores ticks in IDLE and HOLD; tick_dropped is not asserted in that case.
  - A read already in flight completes, and OUT0 is still emitted.
- tick_dropped: asserted for a sample_tick&play in FETCH, WAIT_DATA, OUT0 or OUT1. The tick is not queued.
- Restart in IDLE or HOLD:
  - flash_address = direction ? 0 : MAX_ADDR.
  - Go to IDLE; the HOLD word is discarded.
  - No audio_valid is emitted.
- Restart in FETCH or WAIT_DATA:
  - Set restart_pending and complete the Avalon transaction; the bus is never abandoned mid-read.
  - On readdatavalid, discard the data, apply the restart address, clear the pending flag and go to IDLE.
- Restart in OUT0 or OUT1: the output still fires; the restart is applied next cycle, overriding the OUT1 advance.
- Restart and sample_tick in the same cycle: restart wins and the tick is ignored, with no tick_dropped.
- A direction change mid-word affects only the next address advance and the next word's sample order.
- audio_data holds its last value when paused and after a restart.

Test Plan:
- Reset, then play=1, direction=1; memory model returns word(A) = {A[15:0]^16'hFFFF, A[15:0]} with 2 waitrequest cycles and 1-cycle valid latency.
  - Ticks every 20 clks give audio_data 0x0000, 0xFFFF, 0x0001, 0xFFFE.
  - flash_address goes 0, 1, 2.
- Forward wrap: load flash_address=MAX_ADDR via restart with direction=0, then set direction=1 before the first advance.
  - Sample order is high half, low half.
  - The next read address is 0.
- Backward from restart with direction=0: reads MAX_ADDR, MAX_ADDR-1, MAX_ADDR-2.
  - Each word emits its high half then its low half.
- Pause: play=0 for 5 ticks while in HOLD.
  - No audio_valid and no tick_dropped.
  - audio_data is held.
  - After play=1, the next tick emits the second half of the same word.
- Restart during WAIT_DATA with readdatavalid delayed 10 cycles:
  - flash_read is not re-asserted early.
  - The data is discarded with no audio_valid.
  - The next read is at address 0.
- Tick arriving 1 cycle after an accepted tick (in FETCH): tick_dropped=1 for one cycle; sample sequence unchanged.
